// File: rtl/bs_turn_controller.sv
// Turn sequencer for the two-board Battleship datapath.
// Conditions the three player buttons, runs placement / alternating fire /
// game-over sequencing, and drives the ship-source select, attack-register
// load strobes, datapath clear and the 7-segment word selects for both boards.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// CLEAR    | one-cycle datapath clear after reset or new-game request
// PLACE    | ship registers follow switches; wait for both confirms
// TURN_A   | A to move; press_a with ok_a fires, otherwise error pulse
// FIRE_A   | one-cycle load strobe into A's attack register
// SETTLE_A | let hit logic settle, then check whether B is still alive
// TURN_B   | B to move; mirror of TURN_A
// FIRE_B   | one-cycle load strobe into B's attack register
// SETTLE_B | let hit logic settle, then check whether A is still alive
// OVER     | winner/loser shown until a new game is requested

module bs_turn_controller #(
    parameter int DB_CYCLES = 500000,
    parameter int SETTLE    = 2
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       btn_a,
    input  logic       btn_b,
    input  logic       btn_new,
    input  logic       ok_a,
    input  logic       ok_b,
    input  logic       liv_a,
    input  logic       liv_b,
    output logic       st,
    output logic       ldr2a,
    output logic       ldr2b,
    output logic       clr_dp,
    output logic [1:0] disp_a,
    output logic [1:0] disp_b,
    output logic [1:0] turn,
    output logic       err_a,
    output logic       err_b
);

    localparam int              DB_W        = $clog2(DB_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DB_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ONE      = DB_W'(1);
    localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);

    localparam logic [3:0] S_CLEAR    = 4'd0;
    localparam logic [3:0] S_PLACE    = 4'd1;
    localparam logic [3:0] S_TURN_A   = 4'd2;
    localparam logic [3:0] S_FIRE_A   = 4'd3;
    localparam logic [3:0] S_SETTLE_A = 4'd4;
    localparam logic [3:0] S_TURN_B   = 4'd5;
    localparam logic [3:0] S_FIRE_B   = 4'd6;
    localparam logic [3:0] S_SETTLE_B = 4'd7;
    localparam logic [3:0] S_OVER     = 4'd8;

    localparam logic [1:0] W_BLANK = 2'd0;
    localparam logic [1:0] W_PLAY  = 2'd1;
    localparam logic [1:0] W_WIN   = 2'd2;
    localparam logic [1:0] W_LOSE  = 2'd3;

    // bit 0 = A, bit 1 = B, bit 2 = new game
    logic [2:0]      btn_raw;
    logic [2:0]      sync_1;
    logic [2:0]      sync_2;
    logic [2:0]      db_level;
    logic [2:0]      db_level_q;
    logic [2:0]      press;
    logic [DB_W-1:0] db_cnt [3];

    logic            press_a;
    logic            press_b;
    logic            press_new;

    logic [3:0]      state;
    logic [3:0]      state_next;
    logic            winner_a;
    logic            winner_next;
    logic            conf_a;
    logic            conf_b;
    logic [3:0]      settle_cnt;
    logic            settle_done;

    assign btn_raw   = {btn_new, btn_b, btn_a};
    assign press_a   = press[0];
    assign press_b   = press[1];
    assign press_new = press[2];

    // Two-flop synchronizer on the raw asynchronous buttons.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= btn_raw;
            sync_2 <= sync_1;
        end
    end

    // Debounce: the level follows the synchronized input only after it has
    // disagreed for DB_CYCLES consecutive clocks; any agreeing clock restarts.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            db_level <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync_2[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_level[i] <= sync_2[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_ONE;
                end
            end
        end
    end

    // One-cycle press pulse on each debounced rising edge.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            db_level_q <= '0;
            press      <= '0;
        end else begin
            db_level_q <= db_level;
            press      <= db_level & ~db_level_q;
        end
    end

    assign settle_done = (settle_cnt == 4'd0);

    // Next-state logic; a new-game press overrides every other transition.
    always_comb begin
        state_next  = state;
        winner_next = winner_a;
        case (state)
            S_CLEAR: begin
                state_next = S_PLACE;
            end
            S_PLACE: begin
                if (conf_a && conf_b) begin
                    state_next = S_TURN_A;
                end
            end
            S_TURN_A: begin
                if (press_a && ok_a) begin
                    state_next = S_FIRE_A;
                end
            end
            S_FIRE_A: begin
                state_next = S_SETTLE_A;
            end
            S_SETTLE_A: begin
                if (settle_done) begin
                    if (!liv_b) begin
                        state_next  = S_OVER;
                        winner_next = 1'b1;
                    end else begin
                        state_next = S_TURN_B;
                    end
                end
            end
            S_TURN_B: begin
                if (press_b && ok_b) begin
                    state_next = S_FIRE_B;
                end
            end
            S_FIRE_B: begin
                state_next = S_SETTLE_B;
            end
            S_SETTLE_B: begin
                if (settle_done) begin
                    if (!liv_a) begin
                        state_next  = S_OVER;
                        winner_next = 1'b0;
                    end else begin
                        state_next = S_TURN_A;
                    end
                end
            end
            S_OVER: begin
                state_next = S_OVER;
            end
            default: begin
                state_next = S_CLEAR;
            end
        endcase
        if (press_new) begin
            state_next = S_CLEAR;
        end
    end

    // State and winner registers.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state    <= S_CLEAR;
            winner_a <= 1'b0;
        end else begin
            state    <= state_next;
            winner_a <= winner_next;
        end
    end

    // Confirm flags live only while the FSM stays in PLACE.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            conf_a <= 1'b0;
            conf_b <= 1'b0;
        end else if (state == S_PLACE && state_next == S_PLACE) begin
            conf_a <= conf_a | press_a;
            conf_b <= conf_b | press_b;
        end else begin
            conf_a <= 1'b0;
            conf_b <= 1'b0;
        end
    end

    // Settle down-counter: loaded during the fire cycle, so each settle state
    // lasts SETTLE clocks before the alive flag is sampled.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            settle_cnt <= '0;
        end else if (state == S_FIRE_A || state == S_FIRE_B) begin
            settle_cnt <= SETTLE_LAST;
        end else if ((state == S_SETTLE_A || state == S_SETTLE_B) && !settle_done) begin
            settle_cnt <= settle_cnt - 4'd1;
        end
    end

    // Registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            clr_dp <= 1'b1;
            st     <= 1'b0;
            ldr2a  <= 1'b0;
            ldr2b  <= 1'b0;
            disp_a <= W_BLANK;
            disp_b <= W_BLANK;
            turn   <= 2'b00;
            err_a  <= 1'b0;
            err_b  <= 1'b0;
        end else begin
            clr_dp <= (state_next == S_CLEAR);
            st     <= (state_next != S_CLEAR) && (state_next != S_PLACE);
            ldr2a  <= (state_next == S_FIRE_A);
            ldr2b  <= (state_next == S_FIRE_B);
            turn   <= (state_next == S_TURN_A) ? 2'b01 :
                      (state_next == S_TURN_B) ? 2'b10 : 2'b00;
            if (state_next == S_PLACE) begin
                disp_a <= W_PLAY;
                disp_b <= W_PLAY;
            end else if (state_next == S_OVER) begin
                disp_a <= winner_next ? W_WIN  : W_LOSE;
                disp_b <= winner_next ? W_LOSE : W_WIN;
            end else begin
                disp_a <= W_BLANK;
                disp_b <= W_BLANK;
            end
            err_a <= (state == S_TURN_A) && press_a && !ok_a && !press_new;
            err_b <= (state == S_TURN_B) && press_b && !ok_b && !press_new;
        end
    end

endmodule
